// File: rtl/vmem_write_queue_pkg.sv
// Shared constants and types for the text-video-memory write queue.
package vmem_write_queue_pkg;

    localparam logic [3:0] VMEM_REGION = 4'hc;

    // 1680x1050 text mode geometry
    localparam int TEXT_COLS           = 210;
    localparam int TEXT_ROWS           = 65;
    localparam int CLEAR_CELLS_DEFAULT = TEXT_COLS * TEXT_ROWS;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        CLR_WAIT = 2'd1,
        CLEAR    = 2'd2
    } wq_state_t;

endpackage

// File: rtl/vmem_write_queue_fifo.sv
// Circular buffer of {addr, char} entries with count-based full/empty and a
// sticky flag for pushes dropped while full.
module vmem_fifo #(
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 8
) (
    input  logic                         text_mem_clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [ADDR_WIDTH-1:0]        i_addr,
    input  logic [7:0]                   i_char,
    input  logic                         i_pop,
    output logic [ADDR_WIDTH-1:0]        o_headAddr,
    output logic [7:0]                   o_headChar,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] r_addrMem [DEPTH];
    logic [7:0]            r_charMem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  w_pushOk;
    logic                  w_popOk;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_headAddr = r_addrMem[r_rdPtr];
    assign o_headChar = r_charMem[r_rdPtr];

    // Full is judged on the count before the edge, so a same-cycle pop never rescues a push
    assign w_pushOk = i_push && !o_full;
    assign w_popOk  = i_pop && !o_empty;

    always_ff @(posedge text_mem_clk) begin
        if (w_pushOk) begin
            r_addrMem[r_wrPtr] <= i_addr;
            r_charMem[r_wrPtr] <= i_char;
        end
    end

    always_ff @(posedge text_mem_clk) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pushOk && !w_popOk) begin
                r_count <= r_count + 1'b1;
            end else if (!w_pushOk && w_popOk) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vmem_write_queue.sv
// Queues CPU character stores to text memory and drains them one per cycle to
// the VGA write port; also runs a hardware clear-screen fill.
module vmem_write_queue
    import vmem_write_queue_pkg::*;
#(
    parameter int ADDR_WIDTH  = 15,
    parameter int DEPTH       = 8,
    parameter int CLEAR_CELLS = CLEAR_CELLS_DEFAULT
) (
    input  logic                         text_mem_clk,
    input  logic                         rst,
    input  logic                         cpu_wr_req,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [7:0]                   cpu_char,
    output logic                         cpu_full,
    input  logic                         clr_req,
    input  logic [7:0]                   clr_char,
    output logic                         clr_busy,
    output logic [ADDR_WIDTH-1:0]        vga_addr,
    output logic [7:0]                   vga_data,
    output logic                         vga_wen,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CLEAR_CELLS - 1);

    wq_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_clrCnt;
    logic [7:0]            r_fillChar;
    logic [ADDR_WIDTH-1:0] r_vgaAddr;
    logic [7:0]            r_vgaData;
    logic                  r_vgaWen;

    logic [ADDR_WIDTH-1:0] w_headAddr;
    logic [7:0]            w_headChar;
    logic                  w_empty;
    logic                  w_pop;

    // The fill owns the write port, so queued stores wait until RUN
    assign w_pop = (r_state != CLEAR) && !w_empty;

    vmem_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .text_mem_clk (text_mem_clk),
        .rst          (rst),
        .i_push       (cpu_wr_req),
        .i_addr       (cpu_addr),
        .i_char       (cpu_char),
        .i_pop        (w_pop),
        .o_headAddr   (w_headAddr),
        .o_headChar   (w_headChar),
        .o_count      (level),
        .o_full       (cpu_full),
        .o_empty      (w_empty),
        .o_overflow   (overflow)
    );

    always_ff @(posedge text_mem_clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_clrCnt   <= '0;
            r_fillChar <= '0;
            r_vgaAddr  <= '0;
            r_vgaData  <= '0;
            r_vgaWen   <= 1'b0;
        end else begin
            r_vgaWen <= 1'b0;
            case (r_state)
                RUN, CLR_WAIT: begin
                    if (!w_empty) begin
                        r_vgaAddr <= w_headAddr;
                        r_vgaData <= w_headChar;
                        r_vgaWen  <= 1'b1;
                    end
                    if (r_state == RUN && clr_req) begin
                        r_fillChar <= clr_char;
                        r_state    <= CLR_WAIT;
                    end else if (r_state == CLR_WAIT && w_empty) begin
                        r_clrCnt <= '0;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_vgaAddr <= r_clrCnt;
                    r_vgaData <= r_fillChar;
                    r_vgaWen  <= 1'b1;
                    r_clrCnt  <= r_clrCnt + 1'b1;
                    if (r_clrCnt == LAST_CELL) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign clr_busy = (r_state != RUN);
    assign vga_addr = r_vgaAddr;
    assign vga_data = r_vgaData;
    assign vga_wen  = r_vgaWen;

endmodule

// File: tb/tb_vmem_write_queue.sv
// Directed bench for vmem_write_queue: table vectors for basic queueing, then
// hand sequences for pointer wrap, clear ordering, overflow and reset mid-clear.
module tb_vmem_write_queue;
    import vmem_write_queue_pkg::*;

    localparam int AW    = 15;
    localparam int DEPTH = 8;
    localparam int CELLS = 13650;
    localparam int LW    = $clog2(DEPTH+1);

    logic          text_mem_clk = 1'b0;
    logic          rst          = 1'b0;
    logic          cpu_wr_req   = 1'b0;
    logic [AW-1:0] cpu_addr     = '0;
    logic [7:0]    cpu_char     = '0;
    logic          clr_req      = 1'b0;
    logic [7:0]    clr_char     = '0;
    logic          cpu_full;
    logic          clr_busy;
    logic [AW-1:0] vga_addr;
    logic [7:0]    vga_data;
    logic          vga_wen;
    logic [LW-1:0] level;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          push;
        logic [AW-1:0] addr;
        logic [7:0]    ch;
        logic          eWen;
        logic [AW-1:0] eAddr;
        logic [7:0]    eData;
        logic [LW-1:0] eLevel;
        logic          eFull;
    } vec_t;

    vec_t vecs[8];

    vmem_write_queue #(
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .CLEAR_CELLS (CELLS)
    ) dut (
        .text_mem_clk (text_mem_clk),
        .rst          (rst),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_addr     (cpu_addr),
        .cpu_char     (cpu_char),
        .cpu_full     (cpu_full),
        .clr_req      (clr_req),
        .clr_char     (clr_char),
        .clr_busy     (clr_busy),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .vga_wen      (vga_wen),
        .level        (level),
        .overflow     (overflow)
    );

    always #5 text_mem_clk = ~text_mem_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge text_mem_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic push, input logic [AW-1:0] a, input logic [7:0] c,
                                 input logic clr, input logic [7:0] fill);
        cpu_wr_req = push;
        cpu_addr   = a;
        cpu_char   = c;
        clr_req    = clr;
        clr_char   = fill;
        tick();
        cpu_wr_req = 1'b0;
        clr_req    = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkWrite(input string name, input logic eWen, input logic [AW-1:0] eAddr,
                              input logic [7:0] eData);
        checkOutput({name, ".wen"}, 32'(vga_wen), 32'(eWen));
        checkOutput({name, ".addr"}, 32'(vga_addr), 32'(eAddr));
        checkOutput({name, ".data"}, 32'(vga_data), 32'(eData));
    endtask

    initial begin
        int bad;
        int firstBad;
        int cyc;

        vecs[0] = '{1'b1, 15'h0042, 8'h41, 1'b0, 15'h0000, 8'h00, 4'd1, 1'b0};
        vecs[1] = '{1'b0, 15'h0000, 8'h00, 1'b1, 15'h0042, 8'h41, 4'd0, 1'b0};
        vecs[2] = '{1'b0, 15'h0000, 8'h00, 1'b0, 15'h0042, 8'h41, 4'd0, 1'b0};
        vecs[3] = '{1'b1, 15'h0100, 8'h55, 1'b0, 15'h0042, 8'h41, 4'd1, 1'b0};
        vecs[4] = '{1'b1, 15'h0101, 8'h66, 1'b1, 15'h0100, 8'h55, 4'd1, 1'b0};
        vecs[5] = '{1'b1, 15'h0102, 8'h77, 1'b1, 15'h0101, 8'h66, 4'd1, 1'b0};
        vecs[6] = '{1'b0, 15'h0000, 8'h00, 1'b1, 15'h0102, 8'h77, 4'd0, 1'b0};
        vecs[7] = '{1'b0, 15'h0000, 8'h00, 1'b0, 15'h0102, 8'h77, 4'd0, 1'b0};

        rst = 1'b0;
        repeat (3) tick();
        checkWrite("reset", 1'b0, 15'h0000, 8'h00);
        checkOutput("reset.level", 32'(level), 0);
        checkOutput("reset.full", 32'(cpu_full), 0);
        checkOutput("reset.busy", 32'(clr_busy), 0);
        checkOutput("reset.ovf", 32'(overflow), 0);

        rst = 1'b1;
        idle();
        checkWrite("release", 1'b0, 15'h0000, 8'h00);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].push, vecs[i].addr, vecs[i].ch, 1'b0, 8'h00);
            checkWrite($sformatf("vec%0d", i), vecs[i].eWen, vecs[i].eAddr, vecs[i].eData);
            checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].eLevel));
            checkOutput($sformatf("vec%0d.full", i), 32'(cpu_full), 32'(vecs[i].eFull));
            checkOutput($sformatf("vec%0d.busy", i), 32'(clr_busy), 0);
        end

        // Pointer wrap: push every cycle so each entry pops the cycle after it lands
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, AW'(16'h0400 + i), 8'(8'h80 + i), 1'b0, 8'h00);
            if (i == 0) checkOutput("wrap0.wen", 32'(vga_wen), 0);
            else checkWrite($sformatf("wrap%0d", i), 1'b1, AW'(16'h0400 + i - 1), 8'(8'h80 + i - 1));
            checkOutput($sformatf("wrap%0d.level", i), 32'(level), 1);
        end
        idle();
        checkWrite("wrapLast", 1'b1, 15'h0413, 8'h93);
        checkOutput("wrapLast.level", 32'(level), 0);
        idle();
        checkOutput("wrapIdle.wen", 32'(vga_wen), 0);
        checkOutput("wrap.ovf", 32'(overflow), 0);

        // Clear ordering with a store pushed mid-fill
        applyStimulus(1'b1, 15'h0200, 8'h61, 1'b0, 8'h00);
        checkOutput("clrE0.level", 32'(level), 1);
        applyStimulus(1'b1, 15'h0201, 8'h62, 1'b0, 8'h00);
        checkWrite("clrE0", 1'b1, 15'h0200, 8'h61);
        applyStimulus(1'b1, 15'h0202, 8'h63, 1'b0, 8'h00);
        checkWrite("clrE1", 1'b1, 15'h0201, 8'h62);
        applyStimulus(1'b0, '0, 8'h00, 1'b1, 8'h20);
        checkWrite("clrE2", 1'b1, 15'h0202, 8'h63);
        checkOutput("clrReq.busy", 32'(clr_busy), 1);
        checkOutput("clrReq.level", 32'(level), 0);
        idle();
        checkOutput("clrWait.wen", 32'(vga_wen), 0);
        checkOutput("clrWait.busy", 32'(clr_busy), 1);
        bad = 0;
        firstBad = -1;
        for (int k = 0; k < CELLS; k++) begin
            if (k == 5000) applyStimulus(1'b1, 15'h0010, 8'h5a, 1'b0, 8'h00);
            else idle();
            if (vga_wen !== 1'b1 || vga_addr !== AW'(k) || vga_data !== 8'h20 ||
                clr_busy !== (k != CELLS - 1)) begin
                bad++;
                if (firstBad < 0) firstBad = k;
            end
        end
        if (bad != 0) $display("[TB] first bad fill cycle %0d", firstBad);
        checkOutput("clrFillSeq.badCycles", 32'(bad), 0);
        checkOutput("clrPending.level", 32'(level), 1);
        checkOutput("clrDone.busy", 32'(clr_busy), 0);
        idle();
        checkWrite("clrPostFill", 1'b1, 15'h0010, 8'h5a);
        checkOutput("clrPostFill.level", 32'(level), 0);
        idle();
        checkOutput("clrIdle.wen", 32'(vga_wen), 0);

        // Burst overflow while the fill blocks draining; a stray clr_req is ignored
        applyStimulus(1'b0, '0, 8'h00, 1'b1, 8'h2e);
        checkOutput("ovfReq.busy", 32'(clr_busy), 1);
        idle();
        checkOutput("ovfEnterClear.wen", 32'(vga_wen), 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, AW'(16'h0300 + i), 8'(8'h30 + i), 1'b0, 8'h00);
        end
        checkOutput("ovf8.level", 32'(level), 8);
        checkOutput("ovf8.full", 32'(cpu_full), 1);
        checkOutput("ovf8.ovf", 32'(overflow), 0);
        applyStimulus(1'b1, 15'h0308, 8'h38, 1'b1, 8'h00);
        checkOutput("ovf9.level", 32'(level), 8);
        checkOutput("ovf9.full", 32'(cpu_full), 1);
        checkOutput("ovf9.ovf", 32'(overflow), 1);
        cyc = 0;
        while (clr_busy === 1'b1 && cyc < CELLS + 10) begin
            idle();
            cyc++;
        end
        checkOutput("ovfClearEnds.busy", 32'(clr_busy), 0);
        for (int i = 0; i < 8; i++) begin
            idle();
            checkWrite($sformatf("ovfDrain%0d", i), 1'b1, AW'(16'h0300 + i), 8'(8'h30 + i));
        end
        idle();
        checkOutput("ovfDrained.wen", 32'(vga_wen), 0);
        checkOutput("ovfDrained.level", 32'(level), 0);
        checkOutput("ovfDrained.busy", 32'(clr_busy), 0);
        checkOutput("ovfSticky.ovf", 32'(overflow), 1);

        // Reset at clear counter 100
        applyStimulus(1'b0, '0, 8'h00, 1'b1, 8'h41);
        idle();
        repeat (100) idle();
        checkWrite("rstPre", 1'b1, 15'd99, 8'h41);
        rst = 1'b0;
        idle();
        checkWrite("rstMid", 1'b0, 15'h0000, 8'h00);
        checkOutput("rstMid.level", 32'(level), 0);
        checkOutput("rstMid.full", 32'(cpu_full), 0);
        checkOutput("rstMid.busy", 32'(clr_busy), 0);
        checkOutput("rstMid.ovf", 32'(overflow), 0);
        rst = 1'b1;
        idle();
        checkOutput("rstAfter.busy", 32'(clr_busy), 0);
        checkOutput("rstAfter.wen", 32'(vga_wen), 0);
        applyStimulus(1'b1, 15'h0042, 8'h41, 1'b0, 8'h00);
        checkOutput("rstPush.level", 32'(level), 1);
        checkOutput("rstPush.wen", 32'(vga_wen), 0);
        idle();
        checkWrite("rstPushWrite", 1'b1, 15'h0042, 8'h41);
        checkOutput("rstPushWrite.level", 32'(level), 0);
        idle();
        checkOutput("rstPushIdle.wen", 32'(vga_wen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
